reg_bank_write_arbiter: RTL and testbench
=========================================

Name: reg_bank_write_arbiter

Overview:
- Shares the single write port of the 32x32 register bank between two writeback requesters.
  - Port 0: ALU writeback.
  - Port 1: memory-load writeback.
- Per-port valid/ready handshake; fixed priority to port 0 with an aging counter that promotes port 1 after prolonged starvation.
- Drives the bank's writeReg/writeData/regWrite from a registered output stage, so every bank write is glitch-free and cycle-aligned.

Parameters:
- MAX_WAIT, 4, consecutive lost-arbitration cycles after which port 1 takes priority (1..15).
- ZERO_DISCARD, 1, when 1 writes to register 0 are accepted but never issued to the bank.

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- stall  input  1  bank unavailable; no grants while high
- reqValid0  input  1  port 0 write request valid
- reqAddr0  input  5  port 0 destination register
- reqData0  input  32  port 0 write data
- reqReady0  output  1  port 0 accepted this cycle
- reqValid1  input  1  port 1 write request valid
- reqAddr1  input  5  port 1 destination register
- reqData1  input  32  port 1 write data
- reqReady1  output  1  port 1 accepted this cycle
- writeReg  output  5  to bank writeReg (registered)
- writeData  output  32  to bank writeData (registered)
- regWrite  output  1  to bank regWrite (registered, one-cycle pulse per write)
- grantId  output  1  port that produced the current regWrite (registered)

Behaviour:
- Reset (async, active-high): writeReg=0, writeData=0, regWrite=0, grantId=0, waitCnt=0. reqReady0/1 are combinational and are 0 while reset is high.
- Transfer: a port transfers in a cycle when reqValidN=1 and reqReadyN=1 in that cycle.
- Readiness: reqReady0/1 are combinational from valids, stall, waitCnt. They must not depend on data or address.
- At most one reqReady is high per cycle. Both ready are 0 while stall=1.
- Priority state:
  - NORMAL (waitCnt < MAX_WAIT): port 0 wins when both are valid.
  - PROMOTED (waitCnt >= MAX_WAIT): port 1 wins when both are valid.
- waitCnt update per cycle:
  - Cleared on a port 1 transfer, or when reqValid1=0.
  - Otherwise incremented when reqValid1=1, stall=0 and port 1 is not granted.
  - Saturates at MAX_WAIT.
  - Held during stall.
- Latency: a transfer at edge N produces regWrite=1 with writeReg/writeData equal to the transferred values, and grantId equal to the winning port, during cycle N+1.
- regWrite is 0 in any cycle that follows a cycle without a transfer.
- Idle hold: writeReg/writeData/grantId keep their previous values when there is no transfer.
- ZERO_DISCARD=1 and transferred address is 0: the handshake completes normally, regWrite stays 0, and writeReg/writeData/grantId hold.
- Same-address requests in the same cycle: only the winner is written; the loser is written on a later cycle. No cross-port write ordering is guaranteed; upstream owns hazard resolution.
- Stall asserted mid-stream: a write already in the output stage still issues in the next cycle; no new grants occur.
- Reset mid-operation: any pending output write is dropped immediately; regWrite drops asynchronously.
- Requesters must hold reqValid/reqAddr/reqData stable until their ready is sampled high.

Optional Feature:
- Macro: REG_BANK_ARB_FWD_EN.
- Defined: adds the following ports.
  - Inputs: readReg1[4:0], readReg2[4:0], bankData1[31:0], bankData2[31:0].
  - Outputs: fwdData1[31:0], fwdData2[31:0].
- fwdDataK = writeData when regWrite=1, writeReg==readRegK and writeReg!=0; otherwise fwdDataK = bankDataK.
- This is purely combinational and gives read-during-write forwarding for the issuing cycle.
- Undefined: the forwarding ports and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Single write, no contention:
  - Stimulus: reqValid0=1, addr 5, data 0xDEADBEEF at cycle 2.
  - Response: reqReady0=1 in cycle 2; in cycle 3 regWrite=1, writeReg=5, writeData=0xDEADBEEF, grantId=0.
  - Then: regWrite=0 in cycle 4.
- Contention and aging (MAX_WAIT=4):
  - Stimulus: both ports valid continuously (port0 addr 1, port1 addr 2).
  - Response: port 0 wins 4 consecutive cycles; the 5th grant goes to port 1 (grantId=1, writeReg=2 one cycle later); waitCnt returns to 0.
- Zero-register discard:
  - Stimulus: port 1 writes addr 0, data 0x1234.
  - Response: reqReady1=1; regWrite stays 0 the next cycle; writeReg/writeData unchanged.
- Stall:
  - Stimulus: stall=1 for 3 cycles with both ports valid.
  - Response: both ready=0 and no regWrite for the stall duration after the in-flight write.
  - Then: the first grant goes to port 0 one cycle after stall drops.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously while regWrite=1.
  - Response: regWrite, writeReg, writeData, grantId all 0 immediately, before the next clk edge.
- Forwarding (REG_BANK_ARB_FWD_EN defined):
  - Stimulus: issue write addr 7 = 0xCAFE0001; readReg1=7 in the issue cycle, bankData1=0.
  - Response: fwdData1=0xCAFE0001.
  - Then: with readReg2=0 and writeReg=0, fwdData2=bankData2.

Source files
------------

// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
//   Shares the single write port of the 32x32 register bank between two
//   writeback requesters: port 0 (ALU) and port 1 (memory load).
//   Port 0 has fixed priority. Port 1 is promoted after MAX_WAIT
//   consecutive lost-arbitration cycles. Bank write signals come from a
//   registered output stage.
//
// Parameters:
//   MAX_WAIT     - lost cycles before port 1 takes priority (1..15)
//   ZERO_DISCARD - 1: writes to r0 complete their handshake but never issue
//
// Optional feature macro: REG_BANK_ARB_FWD_EN
//   When defined, adds read-during-write forwarding ports
//   readReg1/2, bankData1/2 (in) and fwdData1/2 (out).
//
// Ports:
//   clk, reset          - clock; asynchronous active-high reset
//   stall               - bank unavailable, no grants
//   reqValidN/AddrN/DataN, reqReadyN - per-port valid/ready write request
//   writeReg/writeData/regWrite      - registered bank write port
//   grantId             - port that produced the current regWrite
module reg_bank_write_arbiter #(
    parameter int unsigned MAX_WAIT     = 4,
    parameter bit          ZERO_DISCARD = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        reqValid0,
    input  logic [4:0]  reqAddr0,
    input  logic [31:0] reqData0,
    output logic        reqReady0,
    input  logic        reqValid1,
    input  logic [4:0]  reqAddr1,
    input  logic [31:0] reqData1,
    output logic        reqReady1,
`ifdef REG_BANK_ARB_FWD_EN
    input  logic [4:0]  readReg1,
    input  logic [4:0]  readReg2,
    input  logic [31:0] bankData1,
    input  logic [31:0] bankData2,
    output logic [31:0] fwdData1,
    output logic [31:0] fwdData2,
`endif
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic        regWrite,
    output logic        grantId
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0]  waitCnt_q, waitCnt_d;
    logic [4:0]  writeReg_q, writeReg_d;
    logic [31:0] writeData_q, writeData_d;
    logic        regWrite_q, regWrite_d;
    logic        grantId_q, grantId_d;

    logic        promoted;
    logic        xfer0, xfer1;
    logic [4:0]  selAddr;
    logic [31:0] selData;
    logic        discard;

    assign promoted = (waitCnt_q >= MAX_WAIT_C);

    // Readiness depends only on valids, stall and the aging state so that
    // requesters never see ready toggle with address/data changes.
    always_comb begin
        reqReady0 = 1'b0;
        reqReady1 = 1'b0;
        if (!reset && !stall) begin
            reqReady0 = reqValid0 && (!reqValid1 || !promoted);
            reqReady1 = reqValid1 && (!reqValid0 || promoted);
        end
    end

    assign xfer0   = reqValid0 && reqReady0;
    assign xfer1   = reqValid1 && reqReady1;
    assign selAddr = xfer1 ? reqAddr1 : reqAddr0;
    assign selData = xfer1 ? reqData1 : reqData0;
    assign discard = ZERO_DISCARD && (selAddr == '0);

    always_comb begin
        waitCnt_d   = waitCnt_q;
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        grantId_d   = grantId_q;

        // Clearing takes precedence; otherwise count lost cycles, frozen in stall.
        if (xfer1 || !reqValid1) begin
            waitCnt_d = '0;
        end else if (!stall && (waitCnt_q < MAX_WAIT_C)) begin
            waitCnt_d = waitCnt_q + 4'd1;
        end

        if ((xfer0 || xfer1) && !discard) begin
            regWrite_d  = 1'b1;
            writeReg_d  = selAddr;
            writeData_d = selData;
            grantId_d   = xfer1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt_q   <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
            grantId_q   <= 1'b0;
        end else begin
            waitCnt_q   <= waitCnt_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
            grantId_q   <= grantId_d;
        end
    end

    assign regWrite  = regWrite_q;
    assign writeReg  = writeReg_q;
    assign writeData = writeData_q;
    assign grantId   = grantId_q;

`ifdef REG_BANK_ARB_FWD_EN
    // Bypass the bank read with the value being written this cycle; r0 never forwards.
    assign fwdData1 = (regWrite_q && (writeReg_q == readReg1) && (writeReg_q != '0))
                      ? writeData_q : bankData1;
    assign fwdData2 = (regWrite_q && (writeReg_q == readReg2) && (writeReg_q != '0))
                      ? writeData_q : bankData2;
`endif

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
module tb_reg_bank_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        reqValid0, reqValid1;
    logic [4:0]  reqAddr0, reqAddr1;
    logic [31:0] reqData0, reqData1;
    logic        reqReady0, reqReady1;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic        grantId;
`ifdef REG_BANK_ARB_FWD_EN
    logic [4:0]  readReg1, readReg2;
    logic [31:0] bankData1, bankData2;
    logic [31:0] fwdData1, fwdData2;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank_write_arbiter #(
        .MAX_WAIT    (4),
        .ZERO_DISCARD(1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .reqValid0(reqValid0),
        .reqAddr0 (reqAddr0),
        .reqData0 (reqData0),
        .reqReady0(reqReady0),
        .reqValid1(reqValid1),
        .reqAddr1 (reqAddr1),
        .reqData1 (reqData1),
        .reqReady1(reqReady1),
`ifdef REG_BANK_ARB_FWD_EN
        .readReg1 (readReg1),
        .readReg2 (readReg2),
        .bankData1(bankData1),
        .bankData2(bankData2),
        .fwdData1 (fwdData1),
        .fwdData2 (fwdData2),
`endif
        .writeReg (writeReg),
        .writeData(writeData),
        .regWrite (regWrite),
        .grantId  (grantId)
    );

    typedef struct {
        logic        st;
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic        gid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic r0, input logic r1, input logic rw, input logic [4:0] wr,
                       input logic [31:0] wd, input logic gid);
        vec_t v;
        v.st = st; v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.rw = rw; v.wr = wr; v.wd = wd; v.gid = gid;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        stall = st; reqValid0 = v0; reqAddr0 = a0; reqData0 = d0;
        reqValid1 = v1; reqAddr1 = a1; reqData1 = d1;
    endtask

    localparam logic [31:0] DA = 32'h000000A1;
    localparam logic [31:0] DB = 32'h000000B2;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // st v0 a0 d0            v1 a1 d1             r0 r1 rw wr  wd            gid
        add(0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 0,  0,            0);
        add(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,             1, 0, 1, 5,  32'hDEADBEEF, 0);
        add(0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 5,  32'hDEADBEEF, 0);
        add(0, 0, 0, 0,            1, 9, 32'h11110009,  0, 1, 1, 9,  32'h11110009, 1);
        // contention: four port-0 wins, then promotion of port 1
        for (int i = 0; i < 4; i++)
            add(0, 1, 1, DA,       1, 2, DB,            1, 0, 1, 1,  DA,           0);
        add(0, 1, 1, DA,           1, 2, DB,            0, 1, 1, 2,  DB,           1);
        add(0, 1, 1, DA,           1, 2, DB,            1, 0, 1, 1,  DA,           0);
        // r0 writes: handshake completes, nothing issued, outputs hold
        add(0, 0, 0, 0,            1, 0, 32'h00001234,  0, 1, 0, 1,  DA,           0);
        add(0, 1, 0, 32'h5678,     0, 0, 0,             1, 0, 0, 1,  DA,           0);
        for (int i = 0; i < 3; i++)
            add(1, 1, 1, DA,       1, 2, DB,            0, 0, 0, 1,  DA,           0);
        // aging count must freeze across a stall
        for (int i = 0; i < 3; i++)
            add(0, 1, 1, DA,       1, 2, DB,            1, 0, 1, 1,  DA,           0);
        for (int i = 0; i < 2; i++)
            add(1, 1, 1, DA,       1, 2, DB,            0, 0, 0, 1,  DA,           0);
        add(0, 1, 1, DA,           1, 2, DB,            1, 0, 1, 1,  DA,           0);
        add(0, 1, 1, DA,           1, 2, DB,            0, 1, 1, 2,  DB,           1);
        add(0, 1, 31, 32'hFFFFFFFF, 0, 0, 0,            1, 0, 1, 31, 32'hFFFFFFFF, 0);
        add(0, 0, 0, 0,            0, 0, 0,             0, 0, 0, 31, 32'hFFFFFFFF, 0);

`ifdef REG_BANK_ARB_FWD_EN
        readReg1 = '0; readReg2 = '0; bankData1 = '0; bankData2 = '0;
`endif
        // reset state, with requests pending to prove ready is gated
        reset = 1'b1;
        drive(0, 1, 3, 32'h3, 1, 4, 32'h4);
        #1;
        check("rst.ready0", {31'd0, reqReady0}, 32'd0);
        check("rst.ready1", {31'd0, reqReady1}, 32'd0);
        check("rst.regWrite", {31'd0, regWrite}, 32'd0);
        check("rst.writeReg", {27'd0, writeReg}, 32'd0);
        check("rst.writeData", writeData, 32'd0);
        check("rst.grantId", {31'd0, grantId}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].st, vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            #1;
            check($sformatf("v%0d.ready0", i), {31'd0, reqReady0}, {31'd0, vecs[i].r0});
            check($sformatf("v%0d.ready1", i), {31'd0, reqReady1}, {31'd0, vecs[i].r1});
            @(posedge clk);
            #1;
            check($sformatf("v%0d.regWrite", i), {31'd0, regWrite}, {31'd0, vecs[i].rw});
            check($sformatf("v%0d.writeReg", i), {27'd0, writeReg}, {27'd0, vecs[i].wr});
            check($sformatf("v%0d.writeData", i), writeData, vecs[i].wd);
            check($sformatf("v%0d.grantId", i), {31'd0, grantId}, {31'd0, vecs[i].gid});
        end

        // in-flight write issues during the first stall cycle; no new grants
        @(negedge clk);
        drive(0, 1, 3, 32'h33333333, 0, 0, 0);
        @(negedge clk);
        drive(1, 1, 1, DA, 1, 2, DB);
        #1;
        check("stallA.regWrite", {31'd0, regWrite}, 32'd1);
        check("stallA.writeReg", {27'd0, writeReg}, 32'd3);
        check("stallA.ready0", {31'd0, reqReady0}, 32'd0);
        check("stallA.ready1", {31'd0, reqReady1}, 32'd0);
        @(posedge clk);
        #1;
        check("stallB.regWrite", {31'd0, regWrite}, 32'd0);
        check("stallB.writeData", writeData, 32'h33333333);
        @(negedge clk);
        drive(0, 1, 1, DA, 1, 2, DB);
        #1;
        check("stallC.ready0", {31'd0, reqReady0}, 32'd1);
        @(posedge clk);
        #1;
        check("stallC.regWrite", {31'd0, regWrite}, 32'd1);
        check("stallC.grantId", {31'd0, grantId}, 32'd0);
        check("stallC.writeReg", {27'd0, writeReg}, 32'd1);

`ifdef REG_BANK_ARB_FWD_EN
        @(negedge clk);
        drive(0, 1, 7, 32'hCAFE0001, 0, 0, 0);
        readReg1 = 5'd7; bankData1 = '0;
        readReg2 = 5'd0; bankData2 = 32'h55555555;
        @(posedge clk);
        #1;
        check("fwd.data1", fwdData1, 32'hCAFE0001);
        check("fwd.data2", fwdData2, 32'h55555555);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        bankData1 = 32'h0BADF00D;
        @(posedge clk);
        #1;
        check("fwd.idle1", fwdData1, 32'h0BADF00D);
`endif

        // asynchronous reset while a write is issuing
        @(negedge clk);
        drive(0, 1, 12, 32'hC0C0C0C0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rstmid.pre", {31'd0, regWrite}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.regWrite", {31'd0, regWrite}, 32'd0);
        check("rstmid.writeReg", {27'd0, writeReg}, 32'd0);
        check("rstmid.writeData", writeData, 32'd0);
        check("rstmid.grantId", {31'd0, grantId}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("rstmid.after", {31'd0, regWrite}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
